mdu_iter: RTL

- Parametrised multi-cycle RISC-V M-extension multiply/divide unit.
- Sits beside the single-cycle ALU in the execute stage.
- Takes all MUL/DIV/REM traffic off the combinational path.
- Valid/ready on both sides; one operation in flight; supports pipeline flush.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_iter_if.sv | 36 +++
 rtl/div_restoring_step.sv | 34 +++
 rtl/mdu_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared types, constants and helpers for the iterative
//                RISC-V M-extension multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    // RISC-V funct3 encodings for the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Quotient returned for a divide by zero; sliced down to XLEN (XLEN <= 64)
    localparam logic [63:0] c_DIV_ZERO_QUOT = '1;

    // First operand is two's complement for these ops (MUL low half is
    // sign-agnostic, so treating it as signed is harmless)
    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter_if.sv
// ============================================================================
//  Module      : mdu_iter_if
//  Description : Request/response bundle for mdu_iter. The master side issues
//                operations and consumes results; the slave side is the unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [4:0]      tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      out_tag;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

`default_nettype wire

// File: rtl/div_restoring_step.sv
// ============================================================================
//  Module      : div_restoring_step
//  Description : One radix-2 restoring-division iteration on magnitudes.
//                Shifts the next dividend bit (MSB of quot) into the partial
//                remainder, subtracts the divisor if it fits, and shifts the
//                resulting quotient bit into the LSB of quot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // rem_i < divisor, so the shifted value is < 2*divisor and the top bit of
    // the difference is a clean borrow flag
    assign w_shift = {rem_i, quot_i[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, divisor_i};
    assign w_fits  = ~w_diff[XLEN];

    assign rem_o  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign quot_o = {quot_i[XLEN-2:0], w_fits};
endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
//  Module      : mdu_iter
//  Description : Multi-cycle RISC-V M-extension multiply/divide unit. One op
//                in flight; operands are latched as magnitudes with a result
//                negate flag. Multiply is either a registered single-cycle
//                product or radix-2 shift-add; divide is restoring radix-2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 0,
    parameter int CNT_W    = $clog2(XLEN + 1)
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] c_MUL_LAST = (MUL_ITER != 0) ? CNT_W'(XLEN) : '0;
    localparam logic [XLEN-1:0]  c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_ALL_ONES = c_DIV_ZERO_QUOT[XLEN-1:0];

    mdu_state_e        state_q;
    mdu_op_e           op_q;
    logic [4:0]        tag_q;
    logic [4:0]        out_tag_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc_q;      // mul: {hi, lo} product; div: {rem, quot}
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              spec_q;     // divide special case, answer held in acc_q low half
    logic              out_valid_q;

    // ---------------- request decode ----------------
    mdu_op_e         w_op;
    logic            w_sa, w_sb, w_is_div, w_is_rem, w_div0, w_ovf, w_spec;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_spec_res;

    assign w_op     = mdu_op_e'(bus.op);
    assign w_sa     = is_signed_a(w_op) & bus.src1[XLEN-1];
    assign w_sb     = is_signed_b(w_op) & bus.src2[XLEN-1];
    assign w_mag_a  = w_sa ? -bus.src1 : bus.src1;
    assign w_mag_b  = w_sb ? -bus.src2 : bus.src2;
    assign w_is_div = bus.op[2];
    assign w_is_rem = bus.op[2] & bus.op[1];
    assign w_div0   = (bus.src2 == '0);
    assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (bus.src1 == c_MIN_NEG) && (bus.src2 == c_ALL_ONES);
    assign w_spec   = w_is_div & (w_div0 | w_ovf);

    // Answer for divide-by-zero and signed overflow, fixed at accept time
    always_comb begin
        w_spec_res = bus.src1;
        if (w_div0) begin
            w_spec_res = w_is_rem ? bus.src1 : c_ALL_ONES;
        end else if (w_is_rem) begin
            w_spec_res = '0;
        end
    end

    // ---------------- multiplier datapath ----------------
    logic [2*XLEN-1:0] w_mul_step, w_mul_mag, w_mul_signed;
    logic [XLEN-1:0]   w_mul_res;

    generate
        if (MUL_ITER != 0) begin : g_mul_iter
            logic [XLEN:0] w_sum;
            assign w_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                                (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
            assign w_mul_step = {w_sum, acc_q[XLEN-1:1]};
            assign w_mul_mag  = acc_q;
        end else begin : g_mul_single
            assign w_mul_step = acc_q;
            assign w_mul_mag  = {{XLEN{1'b0}}, opa_q} * {{XLEN{1'b0}}, opb_q};
        end
    endgenerate

    assign w_mul_signed = neg_q ? -w_mul_mag : w_mul_mag;
    assign w_mul_res    = (op_q == OP_MUL) ? w_mul_signed[XLEN-1:0]
                                           : w_mul_signed[2*XLEN-1:XLEN];

    // ---------------- divider datapath ----------------
    logic [XLEN-1:0] w_rem_n, w_quot_n, w_rem, w_quot, w_div_res;

    div_restoring_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quot_i    (acc_q[XLEN-1:0]),
        .divisor_i (opb_q),
        .rem_o     (w_rem_n),
        .quot_o    (w_quot_n)
    );

    assign w_rem  = acc_q[2*XLEN-1:XLEN];
    assign w_quot = acc_q[XLEN-1:0];

    // Final divide result: special answer, or sign-corrected quotient/remainder
    always_comb begin
        w_div_res = neg_q ? -w_quot : w_quot;
        if (spec_q) begin
            w_div_res = w_quot;
        end else if (op_q[1]) begin
            w_div_res = neg_q ? -w_rem : w_rem;
        end
    end

    // Control FSM with registered outputs; flush aborts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            tag_q       <= '0;
            out_tag_q   <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            spec_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= w_op;
                        tag_q  <= bus.tag;
                        opa_q  <= w_mag_a;
                        opb_q  <= w_mag_b;
                        neg_q  <= w_is_rem ? w_sa : (w_sa ^ w_sb);
                        spec_q <= w_spec;
                        cnt_q  <= '0;
                        if (w_spec) begin
                            acc_q <= {{XLEN{1'b0}}, w_spec_res};
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        end
                        state_q <= w_is_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (cnt_q == c_MUL_LAST) begin
                        result_q    <= w_mul_res;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        acc_q <= w_mul_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (spec_q || (cnt_q == c_DIV_LAST)) begin
                        result_q    <= w_div_res;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        acc_q <= {w_rem_n, w_quot_n};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_tag   = out_tag_q;
endmodule

`default_nettype wire
